// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared widths, default requester count, zero-register index and one-hot helper for the writeback arbiter
package regfile_ctrl_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREQ = 3;
  localparam int MAX_NREQ = 8;
  localparam int REG_ZERO = 0;
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    return MAX_NREQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set req_i bit from ptr_i upward; gnt_o one-hot or zero, idx_o its index
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = PW'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter (iReqValid/iReqAddr/iReqData -> oReqReady) driving a registered write port (oWrite/oAddrC/oRegC/oGrant) plus a pending-write scoreboard (iIssue/iIssueAddr -> oIssueStall, iAddrA/iAddrB -> oBusyA/oBusyB)
module regfile_wb_arbiter #(
  parameter int NREQ = regfile_ctrl_pkg::NREQ,
  parameter int AW = regfile_ctrl_pkg::AW,
  parameter int DW = regfile_ctrl_pkg::DW
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NREQ-1:0]   iReqValid,
  input  logic [AW*NREQ-1:0] iReqAddr,
  input  logic [DW*NREQ-1:0] iReqData,
  output logic [NREQ-1:0]   oReqReady,
  output logic              oWrite,
  output logic [AW-1:0]     oAddrC,
  output logic [DW-1:0]     oRegC,
  output logic [NREQ-1:0]   oGrant,
  input  logic              iIssue,
  input  logic [AW-1:0]     iIssueAddr,
  output logic              oIssueStall,
  input  logic [AW-1:0]     iAddrA,
  input  logic [AW-1:0]     iAddrB,
  output logic              oBusyA,
  output logic              oBusyB
);
  import regfile_ctrl_pkg::*;
  localparam int PW = $clog2(NREQ);
  logic [NREQ-1:0] gnt;
  logic [PW-1:0] idx, ptr_q, ptr_d;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic xfer, wr_d, set;
  logic [(1<<AW)-1:0] busy_q, busy_d;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i(iReqValid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  assign oReqReady = iRst ? '0 : gnt;
  assign xfer = |oReqReady;
  assign sel_addr = iReqAddr[idx*AW +: AW];
  assign sel_data = iReqData[idx*DW +: DW];
  assign wr_d = xfer && sel_addr != AW'(REG_ZERO);
  assign ptr_d = !xfer ? ptr_q : (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
  assign set = iIssue && iIssueAddr != AW'(REG_ZERO) && !busy_q[iIssueAddr];
  assign oIssueStall = iIssue && iIssueAddr != AW'(REG_ZERO) && busy_q[iIssueAddr];
  assign oBusyA = busy_q[iAddrA];
  assign oBusyB = busy_q[iAddrB];
  // clear on the edge the register file captures; a same-address set is a new pending write and wins
  always_comb begin
    busy_d = busy_q;
    if (oWrite) busy_d[oAddrC] = 1'b0;
    if (set) busy_d[iIssueAddr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oWrite <= 1'b0;
      oAddrC <= '0;
      oRegC <= '0;
      oGrant <= '0;
      ptr_q <= '0;
      busy_q <= '0;
    end else begin
      oWrite <= wr_d;
      oAddrC <= wr_d ? sel_addr : oAddrC;
      oRegC <= wr_d ? sel_data : oRegC;
      oGrant <= wr_d ? NREQ'(onehot(3'(idx))) : '0;
      ptr_q <= ptr_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write-port scoreboard for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0] req_ready;
  logic wr;
  logic [4:0] addr_c;
  logic [31:0] reg_c;
  logic [2:0] grant;
  logic issue;
  logic [4:0] issue_addr;
  logic issue_stall;
  logic [4:0] addr_a, addr_b;
  logic busy_a, busy_b;
  int chk = 0;
  int err = 0;
  typedef struct {
    logic [4:0] a;
    logic [31:0] d;
    logic [2:0] g;
  } wr_t;
  wr_t q[$];
  logic [31:0] rf [32];
  always #5 clk = ~clk;
  regfile_wb_arbiter dut (
    .iClk(clk),
    .iRst(rst),
    .iReqValid(req_valid),
    .iReqAddr(req_addr),
    .iReqData(req_data),
    .oReqReady(req_ready),
    .oWrite(wr),
    .oAddrC(addr_c),
    .oRegC(reg_c),
    .oGrant(grant),
    .iIssue(issue),
    .iIssueAddr(issue_addr),
    .oIssueStall(issue_stall),
    .iAddrA(addr_a),
    .iAddrB(addr_b),
    .oBusyA(busy_a),
    .oBusyB(busy_b)
  );
  always @(posedge clk) if (wr) rf[addr_c] <= reg_c;
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      chk++;
      if (q.size() == 0) begin
        err++;
        $display("FAIL wr_unexpected addr=%0h data=%0h grant=%b", addr_c, reg_c, grant);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (addr_c !== e.a || reg_c !== e.d || grant !== e.g) begin
          err++;
          $display("FAIL wr_port got addr=%0h data=%0h grant=%b want addr=%0h data=%0h grant=%b",
                   addr_c, reg_c, grant, e.a, e.d, e.g);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic [2:0] g);
    wr_t e;
    e.a = a;
    e.d = d;
    e.g = g;
    q.push_back(e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    issue = 1'b0;
    issue_addr = '0;
    addr_a = 5'd1;
    addr_b = 5'd2;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    check("rst_ready2", 32'(req_ready), 32'h0);
    check("rst_write", 32'(wr), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("fair_ready", 32'(req_ready), 32'(1 << (k % 3)));
      expect_wr(5'(k % 3 + 1), 32'hA + 32'(k % 3), 3'(1 << (k % 3)));
      tick();
    end
    req_valid = '0;
    check("fair_last_write", 32'(wr), 32'h1);
    tick();
    check("fair_idle_write", 32'(wr), 32'h0);
    check("fair_queue_empty", 32'(q.size()), 32'h0);
    issue = 1'b1;
    issue_addr = 5'd5;
    addr_a = 5'd5;
    #1;
    check("sb_issue5_stall", 32'(issue_stall), 32'h0);
    tick();
    issue = 1'b0;
    #1;
    check("sb_busy5", 32'(busy_a), 32'h1);
    issue = 1'b1;
    #1;
    check("sb_reissue5_stall", 32'(issue_stall), 32'h1);
    tick();
    issue = 1'b0;
    #1;
    check("sb_busy5_kept", 32'(busy_a), 32'h1);
    set_req(1, 1'b1, 5'd5, 32'h1234);
    #1;
    check("sb_r5_ready", 32'(req_ready), 32'h2);
    expect_wr(5'd5, 32'h1234, 3'b010);
    tick();
    req_valid = '0;
    check("sb_busy5_during_write", 32'(busy_a), 32'h1);
    tick();
    check("sb_busy5_cleared", 32'(busy_a), 32'h0);
    check("sb_rf5", rf[5], 32'h1234);
    issue = 1'b1;
    issue_addr = 5'd7;
    addr_b = 5'd7;
    tick();
    issue = 1'b0;
    set_req(2, 1'b1, 5'd7, 32'h77);
    #1;
    check("r7_ready", 32'(req_ready), 32'h4);
    expect_wr(5'd7, 32'h77, 3'b100);
    tick();
    req_valid = '0;
    issue = 1'b1;
    #1;
    check("r7_wb_stall", 32'(issue_stall), 32'h1);
    check("r7_busy_b", 32'(busy_b), 32'h1);
    tick();
    issue = 1'b0;
    #1;
    check("r7_cleared", 32'(busy_b), 32'h0);
    issue = 1'b1;
    #1;
    check("r7_reissue_stall", 32'(issue_stall), 32'h0);
    tick();
    issue = 1'b0;
    #1;
    check("r7_set_again", 32'(busy_b), 32'h1);
    set_req(0, 1'b1, 5'd9, 32'h99);
    #1;
    check("r9_ready", 32'(req_ready), 32'h1);
    expect_wr(5'd9, 32'h99, 3'b001);
    tick();
    req_valid = '0;
    issue = 1'b1;
    issue_addr = 5'd9;
    addr_a = 5'd9;
    #1;
    check("r9_issue_stall", 32'(issue_stall), 32'h0);
    tick();
    issue = 1'b0;
    #1;
    check("r9_set_wins", 32'(busy_a), 32'h1);
    set_req(1, 1'b1, 5'd0, 32'hFFFF);
    #1;
    check("r0_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("r0_no_write", 32'(wr), 32'h0);
    issue = 1'b1;
    issue_addr = 5'd0;
    addr_a = 5'd0;
    #1;
    check("r0_issue_stall", 32'(issue_stall), 32'h0);
    check("r0_busy_a", 32'(busy_a), 32'h0);
    tick();
    issue = 1'b0;
    #1;
    check("r0_busy_after", 32'(busy_a), 32'h0);
    issue = 1'b1;
    issue_addr = 5'd3;
    tick();
    issue_addr = 5'd4;
    tick();
    issue = 1'b0;
    addr_a = 5'd3;
    addr_b = 5'd4;
    #1;
    check("mid_busy3", 32'(busy_a), 32'h1);
    check("mid_busy4", 32'(busy_b), 32'h1);
    set_req(0, 1'b1, 5'd3, 32'h33);
    #1;
    check("mid_ready", 32'(req_ready), 32'h1);
    expect_wr(5'd3, 32'h33, 3'b001);
    tick();
    set_req(0, 1'b1, 5'd4, 32'h44);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    check("mid_write_dropped", 32'(wr), 32'h0);
    check("mid_busy3_clr", 32'(busy_a), 32'h0);
    check("mid_busy4_clr", 32'(busy_b), 32'h0);
    addr_a = 5'd7;
    addr_b = 5'd9;
    #1;
    check("mid_busy7_clr", 32'(busy_a), 32'h0);
    check("mid_busy9_clr", 32'(busy_b), 32'h0);
    req_valid = 3'b111;
    #1;
    check("mid_ptr_zero", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();
    tick();
    check("final_queue_empty", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback requesters (ALU, load unit, multiplier) using a round-robin valid/ready handshake.
- Registers the granted write onto the register file write port (write enable, write address, write data).
- Holds a pending-write scoreboard, set at instruction issue and cleared at writeback. Decode uses it to stall read-after-write hazards on operand ports A/B.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
AW, 5, register address width
DW, 32, register data width

Ports:
iClk  in  1  system clock, rising edge
iRst  in  1  reset, synchronous, active-high
iReqValid  in  NREQ  per-requester write request
iReqAddr  in  AW*NREQ  packed destination addresses, requester i at [i*AW +: AW]
iReqData  in  DW*NREQ  packed write data, requester i at [i*DW +: DW]
oReqReady  out  NREQ  one-hot grant; transfer when iReqValid[i] & oReqReady[i]
oWrite  out  1  register file write enable
oAddrC  out  AW  register file write address
oRegC  out  DW  register file write data
oGrant  out  NREQ  one-hot: requester whose data is on oRegC this cycle
iIssue  in  1  instruction issued with a destination register
iIssueAddr  in  AW  destination of the issuing instruction
oIssueStall  out  1  iIssueAddr already pending; issue refused
iAddrA  in  AW  decode operand A address
iAddrB  in  AW  decode operand B address
oBusyA  out  1  operand A has a pending write
oBusyB  out  1  operand B has a pending write

Behaviour:
- Reset: iClk and iRst are the only clock and reset. When iRst is high at a rising edge, the following clear: oWrite=0, oAddrC=0, oRegC=0, oGrant=0, round-robin pointer=0, busy vector=0. oReqReady=0 combinationally while iRst is high. Any in-flight write is dropped.
- Arbitration (combinational): grant the first i with iReqValid[i] set, searching from pointer upward modulo NREQ. oReqReady is one-hot or zero. Requesters may drop valid without a transfer.
- Pointer update: on a transfer from requester g, pointer <= (g+1) mod NREQ. With no transfer, the pointer holds.
- Write port latency is 1 cycle. On the edge after a transfer with address != 0:
  - oWrite=1, oAddrC=addr, oRegC=data, oGrant=onehot(g).
  - Otherwise oWrite=0 and oGrant=0; oAddrC/oRegC hold.
- Address 0 requests are accepted (ready asserted) but produce no write.
- Throughput: one write per cycle. There is no buffering, so a requester that is not granted holds its request.
- Scoreboard: 2^AW busy bits; bit 0 is tied to 0.
  - Set: iIssue & iIssueAddr!=0 & !busy[iIssueAddr] sets the bit at the edge.
  - Clear: on an edge where oWrite=1 (the same edge the register file captures data), busy[oAddrC] <= 0.
  - Simultaneous set and clear of the same address: set wins (new pending write).
- oIssueStall = iIssue & iIssueAddr!=0 & busy[iIssueAddr], combinational.
  - A stalled issue does not change busy.
  - Issuing to an address whose writeback is on oWrite this cycle also stalls; the bit is still set.
- oBusyA = busy[iAddrA], oBusyB = busy[iAddrB], combinational. Address 0 is never busy.
- The cycle after the clearing edge, busy=0 and the register file holds the new value, so no bypass is needed.
- Writebacks to addresses with no busy bit set are legal and pass through unchanged.

Decomposition:
- Package regfile_ctrl_pkg: AW, DW, default NREQ, REG_ZERO=0, and helper function onehot(idx).
- Sub-module rr_arbiter (parameter NREQ): inputs req and pointer; outputs one-hot grant and encoded index. The arbiter instantiates one rr_arbiter.

Test Plan:
- Reset: assert iRst for 2 cycles with all requests valid -> oReqReady=0, oWrite=0, busy=0; after release, the first grant is requester 0.
- Fairness: all three requesters hold valid continuously (addr 1/2/3, data 0xA/0xB/0xC) -> grants 0,1,2,0,...; oWrite each cycle, one cycle after each transfer, with matching addr/data and oGrant.
- Scoreboard: issue r5 -> oBusyA=1 for iAddrA=5; requester 1 writes r5=0x1234 -> busy clears on the oWrite edge; the next cycle oBusyA=0 and a register file read of r5 returns 0x1234.
- Conflicts:
  - Issue r5 while r5 is busy -> oIssueStall=1 and busy unchanged.
  - Issue r7 on the same edge r7's writeback occurs (oWrite, oAddrC=7) -> oIssueStall=1.
  - After the clear, issue r7 -> bit set.
- Zero register: request addr 0 data 0xFFFF -> accepted, oWrite stays 0; issue r0 -> no stall, oBusyA=0 for iAddrA=0.
- Reset mid-operation: busy={r3,r4}, transfer in flight -> iRst for one cycle clears busy, oWrite=0 the next cycle, pointer=0.
